// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch stage: the queued entry layout and PC arithmetic.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  // Next sequential PC; wraps modulo 2^XLEN.
  function automatic logic [FETCH_XLEN-1:0] pc_inc(input logic [FETCH_XLEN-1:0] pc);
    return pc + FETCH_XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a flush that clears all state.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  fetch_entry_t       i_push_entry,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [CntW-1:0]    o_count,
  output logic               o_empty,
  output logic               o_full,
  output fetch_entry_t       o_head
);

  fetch_entry_t            r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]         r_rptr;
  logic [PtrW-1:0]         r_wptr;
  logic [CntW-1:0]         r_count;

  logic                    w_push;
  logic                    w_pop;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntW'(FIFO_DEPTH));
  assign o_head  = r_mem[r_rptr];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_push = i_push & (~o_full | w_pop) & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_entry;
  end

endmodule

// File: rtl/fetch_stage.sv
// PC generation and instruction fetch in front of a zero-latency ROM, buffering toward decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [CntW-1:0] w_count;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_can_push;
  logic            w_push;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  assign imem_addr = r_pc;

  assign w_pop      = id_valid & id_ready;
  assign w_can_push = fetch_en & (~w_full | w_pop);
  // A redirect discards the word fetched this cycle along with everything queued.
  assign w_push     = w_can_push & ~redirect_valid;

  assign w_push_entry.pc    = r_pc;
  assign w_push_entry.instr = imem_rdata;

  always_comb begin
    w_pc_next = r_pc;
    if (redirect_valid) begin
      w_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (w_push) begin
      w_pc_next = pc_inc(r_pc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .o_count      (w_count),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_head       (w_head)
  );

  // Decode-facing outputs come only from FIFO state, never from id_ready or redirect_valid.
  always_comb begin
    id_valid    = ~w_empty;
    id_instr    = NOP_INSTR;
    id_pc       = '0;
    id_pc_plus4 = XLEN'(4);
    if (!w_empty) begin
      id_instr    = w_head.instr;
      id_pc       = w_head.pc;
      id_pc_plus4 = pc_inc(w_head.pc);
    end
  end

  logic w_unused_count;
  assign w_unused_count = ^w_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic vs a queue model.
module tb_fetch_stage;

  localparam int unsigned XLEN       = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN       (XLEN),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_rdata = rom(imem_addr);

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: the PC to fetch next and the PCs that are queued for decode, in order.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];

  task automatic check_model();
    logic [31:0] hd;
    hd = (m_q.size() > 0) ? m_q[0] : 32'h0;
    check("imem_addr", imem_addr, m_pc);
    check("id_valid", {31'b0, id_valid}, {31'b0, m_q.size() > 0});
    check("id_pc", id_pc, hd);
    check("id_instr", id_instr, (m_q.size() > 0) ? rom(hd) : NOP);
    check("id_pc_plus4", id_pc_plus4, (m_q.size() > 0) ? hd + 32'd4 : 32'd4);
  endtask

  task automatic model_edge();
    bit pop;
    int sz;
    sz  = m_q.size();
    pop = (sz > 0) && id_ready;
    if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc & ~32'h3;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (fetch_en && (sz < int'(FIFO_DEPTH) || pop)) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Inputs are set after a negedge; this advances one clock and checks at the next negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    m_q.delete();
    m_pc = RESET_PC;
    repeat (2) @(negedge clk);
    check_model();
    rst_n = 1'b1;
  endtask

  logic [31:0] held;

  initial begin
    // Continuous stream from reset.
    do_reset();
    check("rst_plus4", id_pc_plus4, 32'd4);
    id_ready = 1'b1;
    tick();
    check("s1_pc", id_pc, 32'h0);
    check("s1_instr", id_instr, 32'h1000_0000);
    tick();
    check("s2_pc", id_pc, 32'h4);
    check("s2_lead", imem_addr, id_pc + 32'd4);
    repeat (6) tick();

    // Backpressure fills the FIFO, then drains without gaps.
    do_reset();
    repeat (5) tick();
    check("bp_addr_hold", imem_addr, 32'h8);
    check("bp_head", id_pc, 32'h0);
    id_ready = 1'b1;
    tick();
    check("bp_d1", id_pc, 32'h4);
    tick();
    check("bp_d2", id_pc, 32'h8);

    // Redirect while full; low address bits are dropped.
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    check("rd_valid0", {31'b0, id_valid}, 32'h0);
    check("rd_addr", imem_addr, 32'h40);
    tick();
    check("rd_valid1", {31'b0, id_valid}, 32'h1);
    check("rd_pc", id_pc, 32'h40);

    // Redirect coinciding with a pop.
    id_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("rp_empty", {31'b0, id_valid}, 32'h0);
    tick();
    check("rp_target", id_pc, 32'h200);

    // Wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("wr_pc", id_pc, 32'hFFFF_FFFC);
    check("wr_plus4", id_pc_plus4, 32'h0);
    tick();
    check("wr_pc2", id_pc, 32'h0);

    // Fetch disabled: FIFO drains, PC holds.
    fetch_en = 1'b0;
    held     = imem_addr;
    repeat (3) tick();
    check("fe_drained", {31'b0, id_valid}, 32'h0);
    check("fe_addr_hold", imem_addr, held);
    fetch_en = 1'b1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      fetch_en       = ($urandom_range(0, 9) < 8);
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 5);
      redirect_pc    = $urandom();
      tick();
    end
    redirect_valid = 1'b0;

    // Asynchronous reset mid-stream, away from any clock edge.
    fetch_en = 1'b1;
    id_ready = 1'b0;
    repeat (3) tick();
    check("ar_pre_valid", {31'b0, id_valid}, 32'h1);
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, id_valid}, 32'h0);
    check("ar_addr", imem_addr, RESET_PC);
    check("ar_pc", id_pc, 32'h0);
    check("ar_instr", id_instr, NOP);
    check("ar_plus4", id_pc_plus4, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
PC-generation and instruction-fetch stage that sits directly upstream of the combinational instruction ROM.
- Drives the ROM word address; the ROM uses bits [9:2] of it.
- Captures the returned instruction word together with its PC into a small FIFO.
- Presents one instruction at a time to decode through a valid/ready handshake.
- Handles branch/jump redirects from later stages by flushing queued instructions and reloading the PC.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- FIFO_DEPTH, 2, number of fetched instructions buffered ahead of decode; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  when low, no new fetch is issued and the PC holds.
- imem_addr  out  XLEN  byte address to instruction ROM; equals current PC.
- imem_rdata  in  32  instruction word returned combinationally by the ROM for imem_addr.
- redirect_valid  in  1  branch/jump taken; one-cycle pulse from execute.
- redirect_pc  in  XLEN  redirect target address.
- id_valid  out  1  head FIFO entry is valid for decode.
- id_ready  in  1  decode accepts the head entry this cycle.
- id_instr  out  32  instruction at FIFO head.
- id_pc  out  XLEN  PC of id_instr.
- id_pc_plus4  out  XLEN  id_pc + 4, modulo 2^XLEN.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst_n low, independent of clk):
  - pc = RESET_PC; FIFO count = 0; read/write pointers = 0.
  - id_valid = 0; id_instr = 32'h0000_0013 (NOP); id_pc = 0; id_pc_plus4 = 4; imem_addr = RESET_PC.
- imem_addr = pc, combinationally from the PC register. The ROM read has zero latency, so imem_rdata is sampled in the same cycle.
- Definitions:
  - pop = id_valid & id_ready.
  - can_push = fetch_en & ((count < FIFO_DEPTH) | pop).
- Normal cycle (redirect_valid = 0):
  - If can_push: write {pc, imem_rdata} at the tail; pc <= pc + 4, wrapping modulo 2^XLEN.
  - If pop: advance the head.
  - Push and pop in the same cycle leave count unchanged; this is legal when the FIFO is full.
- Redirect cycle (redirect_valid = 1) takes priority over everything:
  - FIFO flushed: count <= 0, pointers reset.
  - No push this cycle.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}; the low two bits are ignored.
  - A handshake that completes in the redirect cycle (pop = 1) counts as delivered. Decode owns squashing it; this stage does not.
- Latency:
  - The instruction at pc is pushed in cycle N and appears at id_* in cycle N+1.
  - After a redirect in cycle N, imem_addr = target in cycle N+1 and id_valid = 1 with id_pc = target in cycle N+2.
- Outputs when FIFO is empty: id_valid = 0, id_instr = NOP, id_pc = 0, id_pc_plus4 = 4.
- fetch_en = 0: PC holds and no pushes occur; pops continue, so the FIFO drains.
- Ordering: instructions reach decode in strict PC order, with no duplicates and no skips between redirects.
- id_* outputs depend only on registered state, with no combinational path from id_ready or redirect_valid.

Decomposition:
- Package fetch_pkg holds:
  - localparam NOP_INSTR = 32'h0000_0013.
  - typedef struct packed fetch_entry_t {pc[XLEN-1:0], instr[31:0]}.
  - Function pc_inc returning pc + 4.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with FIFO_DEPTH, push/pop/flush inputs, count, and head outputs; async active-low reset.
- fetch_stage contains the PC register, next-PC logic and handshake glue.

Test Plan:
- Reset then release with id_ready = 1 and ROM word i = 0x1000_0000 + i → cycle 1 has id_pc = 0x0, id_instr = 0x1000_0000; cycle 2 has id_pc = 0x4; continuous one-per-cycle stream with imem_addr leading id_pc by 4.
- Hold id_ready = 0 for 5 cycles from reset → after 2 pushes the FIFO is full and imem_addr holds at 0x8. On release, entries 0x0, 0x4, 0x8 are delivered on consecutive cycles with no gaps or duplicates.
- Full FIFO, assert redirect_valid with redirect_pc = 0x43 → next cycle id_valid = 0 and imem_addr = 0x40; following cycle id_valid = 1, id_pc = 0x40.
- Redirect and pop in the same cycle → popped entry counts as delivered, no other old entry appears afterwards, and the first post-redirect id_pc equals the target.
- Redirect to 0xFFFF_FFFC → delivered id_pc sequence is 0xFFFF_FFFC then 0x0, and id_pc_plus4 for the first entry is 0x0.
- fetch_en = 0 for 3 cycles with id_ready = 1 → FIFO drains to id_valid = 0 and imem_addr is constant. Asserting rst_n = 0 mid-stream clears id_valid immediately, before the next clk edge.
